// File: rtl/block_avg_writer.sv
// block_avg_writer: reduces a raster pixel stream to per-tile averages and writes them row-major into the frame buffer.
module block_avg_writer #(
    parameter int SRC_WIDTH        = 640,
    parameter int SRC_HEIGHT       = 480,
    parameter int HORIZ_BLOCK_SIZE = 16,
    parameter int VERT_BLOCK_SIZE  = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic [7:0]  pix_data,
    output logic [18:0] addrWrite,
    output logic [7:0]  dataWrite,
    output logic        wr_en,
    output logic        frame_done,
    output logic        sync_err
);
    localparam int COLS = SRC_WIDTH / HORIZ_BLOCK_SIZE;
    localparam int ROWS = SRC_HEIGHT / VERT_BLOCK_SIZE;
    localparam int XW   = $clog2(SRC_WIDTH);
    localparam int YW   = $clog2(SRC_HEIGHT + 1);
    localparam int HB   = $clog2(HORIZ_BLOCK_SIZE);
    localparam int CW   = XW - HB;
    localparam int LW   = $clog2(VERT_BLOCK_SIZE);
    localparam int RW   = $clog2(ROWS + 1);
    localparam int HSW  = $clog2(HORIZ_BLOCK_SIZE * 255 + 1);
    localparam int SW   = $clog2(HORIZ_BLOCK_SIZE * VERT_BLOCK_SIZE * 255 + 1);
    localparam logic [XW-1:0] X_LAST = XW'(SRC_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SRC_HEIGHT - 1);
    localparam logic [LW-1:0] L_LAST = LW'(VERT_BLOCK_SIZE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;

    logic [XW-1:0]  x, cx;
    logic [YW-1:0]  y, cy;
    logic [LW-1:0]  lit, cl;
    logic [RW-1:0]  trow, cr;
    logic [CW-1:0]  col;
    logic [HSW-1:0] hsum, hnext;
    logic [SW-1:0]  total;
    logic [SW-9:0]  avg;
    logic [SW-1:0]  acc [COLS];
    logic take, start, resync, fold, emit, last;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state == DRAIN ? IDLE : last ? DRAIN : take ? RUN : state;
    end

    // An SOF pixel always restarts the frame at (0,0), whether from IDLE or mid-frame.
    always_comb begin
        start  = pix_valid && pix_sof && state != DRAIN;
        resync = start && state == RUN && (x != '0 || y != '0);
        take   = pix_valid && (state == RUN || start);
        cx     = start ? '0 : x;
        cy     = start ? '0 : y;
        cl     = start ? '0 : lit;
        cr     = start ? '0 : trow;
        col    = cx[XW-1:HB];
        hnext  = cx[HB-1:0] == '0 ? HSW'(pix_data) : hsum + HSW'(pix_data);
        fold   = take && &cx[HB-1:0];
        total  = (cl == '0 ? '0 : acc[col]) + SW'(hnext);
        avg    = (SW-8)'(((SW+8)'(total) * (SW+8)'(205)) >> 16);
        emit   = fold && cl == L_LAST;
        last   = take && cx == X_LAST && cy == Y_LAST;
    end

    always_ff @(posedge clk) begin
        if (fold) acc[col] <= total;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x          <= '0;
            y          <= '0;
            lit        <= '0;
            trow       <= '0;
            hsum       <= '0;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            addrWrite  <= '0;
            dataWrite  <= '0;
        end else begin
            wr_en      <= emit;
            frame_done <= last;
            if (resync) sync_err <= 1'b1;
            if (emit) begin
                addrWrite <= 19'(cr) * 19'(COLS) + 19'(col);
                dataWrite <= |avg[SW-9:8] ? 8'hff : avg[7:0];
            end
            if (take) begin
                hsum <= hnext;
                x    <= cx == X_LAST ? '0 : cx + XW'(1);
                y    <= cx == X_LAST ? cy + YW'(1) : cy;
                lit  <= cx != X_LAST ? cl : cl == L_LAST ? '0 : cl + LW'(1);
                trow <= cx == X_LAST && cl == L_LAST ? cr + RW'(1) : cr;
            end
        end
    end
endmodule

// File: tb/tb_block_avg_writer.sv
// tb_block_avg_writer: directed checks of tile averaging, ordering, latency, resync and reset on a reduced 64x40 frame.
module tb_block_avg_writer;
    localparam int W = 64;
    localparam int H = 40;
    localparam int NT = 8;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic [7:0]  pix_data = '0;
    logic [18:0] addrWrite;
    logic [7:0]  dataWrite;
    logic        wr_en, frame_done, sync_err;

    block_avg_writer #(.SRC_WIDTH(W), .SRC_HEIGHT(H), .HORIZ_BLOCK_SIZE(16), .VERT_BLOCK_SIZE(20)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
        .addrWrite(addrWrite), .dataWrite(dataWrite), .wr_en(wr_en), .frame_done(frame_done), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [18:0] wa[$];
    logic [7:0]  wd[$];
    int          wc[$];
    int          exp_wc[$];
    logic [18:0] da[$];
    logic [7:0]  tile_val [NT] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd10, 8'd11, 8'd12, 8'd13};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            wa.push_back(addrWrite);
            wd.push_back(dataWrite);
            wc.push_back(cyc);
        end
        if (frame_done) da.push_back(wr_en ? addrWrite : 19'h7ffff);
    end

    task automatic clear();
        wa.delete();
        wd.delete();
        wc.delete();
        exp_wc.delete();
        da.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_valid = 1'b0;
            pix_sof = 1'b0;
        end
    endtask

    // mode 0: constant val, 1: tile-coded row*10+col, 2: ramp (x mod 16)*16
    task automatic stream(input int mode, input logic [7:0] val, input bit gaps, input bit sof, input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            int px, py;
            logic [7:0] d;
            px = i % W;
            py = i / W;
            if (gaps) while ($urandom_range(0, 9) < 3) idle(1);
            d = mode == 0 ? val : mode == 1 ? 8'((py / 20) * 10 + px / 16) : 8'((px % 16) * 16);
            @(negedge clk);
            pix_valid = 1'b1;
            pix_sof = sof && i == first;
            pix_data = d;
            if (px % 16 == 15 && py % 20 == 19) exp_wc.push_back(cyc + 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (wr_en !== 1'b0 || frame_done !== 1'b0 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: wr_en=%b frame_done=%b sync_err=%b want 0 0 0", wr_en, frame_done, sync_err);
        end
        checks++;
        if (addrWrite !== 19'd0 || dataWrite !== 8'd0) begin
            errors++;
            $display("FAIL reset_bus: addr=%0d data=%0d want 0 0", addrWrite, dataWrite);
        end
    endtask

    task automatic test_const(input logic [7:0] v);
        clear();
        stream(0, v, 1'b0, 1'b1, 0, NPIX);
        idle(4);
        checks++;
        if (wa.size() != NT) begin
            errors++;
            $display("FAIL const%0d_count: got %0d want %0d", v, wa.size(), NT);
        end
        for (int i = 0; i < wa.size() && i < NT; i++) begin
            checks++;
            if (wa[i] !== 19'(i) || wd[i] !== v) begin
                errors++;
                $display("FAIL const%0d_write%0d: addr=%0d data=%0d want addr=%0d data=%0d", v, i, wa[i], wd[i], i, v);
            end
        end
        checks++;
        if (da.size() != 1 || da[0] !== 19'(NT - 1)) begin
            errors++;
            $display("FAIL const%0d_frame_done: count=%0d addr=%0d want 1 pulse at %0d", v, da.size(), da.size() ? da[0] : 0, NT - 1);
        end
        checks++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("FAIL const%0d_sync_err: got %b want 0", v, sync_err);
        end
        checks++;
        if (wr_en !== 1'b0 || addrWrite !== 19'(NT - 1) || dataWrite !== v) begin
            errors++;
            $display("FAIL const%0d_hold: wr_en=%b addr=%0d data=%0d want 0 %0d %0d", v, wr_en, addrWrite, dataWrite, NT - 1, v);
        end
    endtask

    task automatic test_tiles_gaps();
        clear();
        stream(1, 8'd0, 1'b1, 1'b1, 0, NPIX);
        idle(4);
        checks++;
        if (wa.size() != NT || exp_wc.size() != NT) begin
            errors++;
            $display("FAIL tiles_count: got %0d writes want %0d", wa.size(), NT);
        end
        for (int i = 0; i < wa.size() && i < NT; i++) begin
            checks++;
            if (wa[i] !== 19'(i) || wd[i] !== tile_val[i]) begin
                errors++;
                $display("FAIL tiles_write%0d: addr=%0d data=%0d want addr=%0d data=%0d", i, wa[i], wd[i], i, tile_val[i]);
            end
            checks++;
            if (i < exp_wc.size() && wc[i] != exp_wc[i]) begin
                errors++;
                $display("FAIL tiles_latency%0d: write cycle %0d want %0d", i, wc[i], exp_wc[i]);
            end
        end
        checks++;
        if (da.size() != 1 || da[0] !== 19'(NT - 1)) begin
            errors++;
            $display("FAIL tiles_frame_done: count=%0d want 1", da.size());
        end
    endtask

    task automatic test_ramp();
        clear();
        stream(2, 8'd0, 1'b0, 1'b1, 0, NPIX);
        idle(4);
        checks++;
        if (wa.size() != NT) begin
            errors++;
            $display("FAIL ramp_count: got %0d want %0d", wa.size(), NT);
        end
        for (int i = 0; i < wd.size(); i++) begin
            checks++;
            if (wd[i] !== 8'd120) begin
                errors++;
                $display("FAIL ramp_data%0d: got %0d want 120", i, wd[i]);
            end
        end
    endtask

    task automatic test_abort();
        clear();
        stream(0, 8'd50, 1'b0, 1'b1, 0, 30 * W + 32);
        stream(0, 8'd100, 1'b0, 1'b1, 0, NPIX);
        idle(4);
        checks++;
        if (wa.size() != 4 + NT) begin
            errors++;
            $display("FAIL abort_count: got %0d want %0d", wa.size(), 4 + NT);
        end
        for (int i = 0; i < wa.size() && i < 4 + NT; i++) begin
            checks++;
            if (wa[i] !== (i < 4 ? 19'(i) : 19'(i - 4)) || wd[i] !== (i < 4 ? 8'd50 : 8'd100)) begin
                errors++;
                $display("FAIL abort_write%0d: addr=%0d data=%0d want addr=%0d data=%0d", i, wa[i], wd[i], i < 4 ? i : i - 4, i < 4 ? 50 : 100);
            end
        end
        checks++;
        if (da.size() != 1 || da[0] !== 19'(NT - 1)) begin
            errors++;
            $display("FAIL abort_frame_done: count=%0d want 1", da.size());
        end
        checks++;
        if (sync_err !== 1'b1) begin
            errors++;
            $display("FAIL abort_sync_err: got %b want 1", sync_err);
        end
    endtask

    task automatic test_mid_reset();
        clear();
        stream(0, 8'd77, 1'b0, 1'b1, 0, 19 * W + 15);
        @(negedge clk);
        rst = 1'b1;
        pix_valid = 1'b1;
        pix_sof = 1'b0;
        pix_data = 8'd77;
        @(negedge clk);
        rst = 1'b0;
        pix_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b0 || frame_done !== 1'b0 || sync_err !== 1'b0 || addrWrite !== 19'd0 || dataWrite !== 8'd0) begin
            errors++;
            $display("FAIL midrst_outputs: wr_en=%b done=%b sync_err=%b addr=%0d data=%0d want all 0", wr_en, frame_done, sync_err, addrWrite, dataWrite);
        end
        stream(0, 8'd33, 1'b0, 1'b0, 0, W * 80);
        idle(4);
        checks++;
        if (wa.size() != 0 || da.size() != 0) begin
            errors++;
            $display("FAIL midrst_nosof_writes: got %0d writes %0d done want 0 0", wa.size(), da.size());
        end
        stream(1, 8'd0, 1'b0, 1'b1, 0, NPIX);
        idle(4);
        checks++;
        if (wa.size() != NT || da.size() != 1) begin
            errors++;
            $display("FAIL midrst_frame_count: got %0d writes %0d done want %0d 1", wa.size(), da.size(), NT);
        end
        for (int i = 0; i < wa.size() && i < NT; i++) begin
            checks++;
            if (wa[i] !== 19'(i) || wd[i] !== tile_val[i]) begin
                errors++;
                $display("FAIL midrst_write%0d: addr=%0d data=%0d want addr=%0d data=%0d", i, wa[i], wd[i], i, tile_val[i]);
            end
        end
        checks++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_sync_err: got %b want 0", sync_err);
        end
    endtask

    initial begin
        test_reset();
        test_const(8'd100);
        test_const(8'd255);
        test_const(8'd0);
        test_tiles_gaps();
        test_ramp();
        test_abort();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
